// File: rtl/energy_sweep_accumulator.sv
// Sums per-phase energies over one sweep and keeps the lowest-energy sweep with its spin state.
// Optional SWEEP_COUNT_EN adds a saturating sweep counter and the index of the best sweep.
module energy_sweep_accumulator #(
   parameter int NUM_PHASES = 36,
   parameter int PIPE_LAT   = 10,
   parameter int ACC_W      = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sweep_start,
   input  logic [11:0]      energy_in,
   input  logic [143:0]     bm_state,
   input  logic             clr_best,
   output logic             busy,
   output logic [ACC_W-1:0] sweep_energy,
   output logic             sweep_valid,
   output logic [ACC_W-1:0] best_energy,
   output logic [143:0]     best_state,
   output logic             best_update
`ifdef SWEEP_COUNT_EN
   ,
   output logic [15:0]      sweep_count,
   output logic [15:0]      best_sweep
`endif
);

   localparam int CNT_MAX = (NUM_PHASES > PIPE_LAT) ? NUM_PHASES : PIPE_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ACC_W-1:0] BEST_INIT = {1'b0, {(ACC_W-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, WAIT, ACCUM, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [143:0]       cand_state_q, cand_state_d;
   logic               busy_q, busy_d;
   logic [ACC_W-1:0]   sweep_energy_q, sweep_energy_d;
   logic               sweep_valid_q, sweep_valid_d;
   logic [ACC_W-1:0]   best_energy_q, best_energy_d;
   logic [143:0]       best_state_q, best_state_d;
   logic               best_update_q, best_update_d;
   logic [ACC_W-1:0]   energy_ext;
`ifdef SWEEP_COUNT_EN
   logic [15:0]        sweep_count_q, sweep_count_d;
   logic [15:0]        best_sweep_q, best_sweep_d;
`endif

   assign energy_ext = {{(ACC_W-12){energy_in[11]}}, energy_in};

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      cand_state_d   = cand_state_q;
      busy_d         = busy_q;
      sweep_energy_d = sweep_energy_q;
      sweep_valid_d  = 1'b0;
      best_energy_d  = best_energy_q;
      best_state_d   = best_state_q;
      best_update_d  = 1'b0;
`ifdef SWEEP_COUNT_EN
      sweep_count_d  = sweep_count_q;
      best_sweep_d   = best_sweep_q;
`endif
      case (state_q)
         IDLE: begin
            if (sweep_start) begin
               cand_state_d = bm_state;
               acc_d        = '0;
               cnt_d        = '0;
               busy_d       = 1'b1;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
               cnt_d   = '0;
               state_d = ACCUM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACCUM: begin
            acc_d = acc_q + energy_ext;
            if (cnt_q == CNT_W'(NUM_PHASES - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            sweep_energy_d = acc_q;
            sweep_valid_d  = 1'b1;
            busy_d         = 1'b0;
            state_d        = IDLE;
            // Strict less-than so a tie keeps the older record.
            if ($signed(acc_q) < $signed(best_energy_q)) begin
               best_energy_d = acc_q;
               best_state_d  = cand_state_q;
               best_update_d = 1'b1;
`ifdef SWEEP_COUNT_EN
               best_sweep_d  = sweep_count_q;
`endif
            end
`ifdef SWEEP_COUNT_EN
            if (sweep_count_q != 16'hFFFF) begin
               sweep_count_d = sweep_count_q + 16'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      // Clearing overrides any record update made in the same cycle.
      if (clr_best) begin
         best_energy_d = BEST_INIT;
         best_state_d  = '0;
         best_update_d = 1'b0;
`ifdef SWEEP_COUNT_EN
         best_sweep_d  = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         acc_q          <= '0;
         cand_state_q   <= '0;
         busy_q         <= 1'b0;
         sweep_energy_q <= '0;
         sweep_valid_q  <= 1'b0;
         best_energy_q  <= BEST_INIT;
         best_state_q   <= '0;
         best_update_q  <= 1'b0;
`ifdef SWEEP_COUNT_EN
         sweep_count_q  <= '0;
         best_sweep_q   <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         cand_state_q   <= cand_state_d;
         busy_q         <= busy_d;
         sweep_energy_q <= sweep_energy_d;
         sweep_valid_q  <= sweep_valid_d;
         best_energy_q  <= best_energy_d;
         best_state_q   <= best_state_d;
         best_update_q  <= best_update_d;
`ifdef SWEEP_COUNT_EN
         sweep_count_q  <= sweep_count_d;
         best_sweep_q   <= best_sweep_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign sweep_energy = sweep_energy_q;
   assign sweep_valid  = sweep_valid_q;
   assign best_energy  = best_energy_q;
   assign best_state   = best_state_q;
   assign best_update  = best_update_q;
`ifdef SWEEP_COUNT_EN
   assign sweep_count  = sweep_count_q;
   assign best_sweep   = best_sweep_q;
`endif

endmodule

// File: tb/tb_energy_sweep_accumulator.sv
// Directed-vector bench for energy_sweep_accumulator; SWEEP_COUNT_EN enables the counter scenario.
module tb_energy_sweep_accumulator;

   localparam int ACC_W = 18;
   localparam logic [ACC_W-1:0] BEST_MAX = 18'd131071;
   localparam logic [11:0] JUNK = 12'd1000;

   logic             clk;
   logic             rst_n;
   logic             sweep_start;
   logic [11:0]      energy_in;
   logic [143:0]     bm_state;
   logic             clr_best;
   logic             busy;
   logic [ACC_W-1:0] sweep_energy;
   logic             sweep_valid;
   logic [ACC_W-1:0] best_energy;
   logic [143:0]     best_state;
   logic             best_update;
`ifdef SWEEP_COUNT_EN
   logic [15:0]      sweep_count;
   logic [15:0]      best_sweep;
`endif

   int n_compared;
   int n_mismatched;
   logic busy_at_21;

   logic [143:0] st1, st2, st3, st4, st5, st6, st7, st8, st9;

   energy_sweep_accumulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sweep_start  (sweep_start),
      .energy_in    (energy_in),
      .bm_state     (bm_state),
      .clr_best     (clr_best),
      .busy         (busy),
      .sweep_energy (sweep_energy),
      .sweep_valid  (sweep_valid),
      .best_energy  (best_energy),
      .best_state   (best_state),
      .best_update  (best_update)
`ifdef SWEEP_COUNT_EN
      ,
      .sweep_count  (sweep_count),
      .best_sweep   (best_sweep)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n       = 1'b0;
      sweep_start = 1'b0;
      clr_best    = 1'b0;
      energy_in   = 12'd0;
      bm_state    = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Runs one sweep starting in the current cycle t and returns at cycle t+48.
   // Outside the sampling window energy_in carries junk so window errors show up.
   task automatic do_sweep(input logic [11:0] e, input logic [143:0] st,
                           input bit spur20, input logic [143:0] spur_st, input bit clr47);
      sweep_start = 1'b1;
      bm_state    = st;
      energy_in   = JUNK;
      tick();
      sweep_start = 1'b0;
      for (int k = 1; k <= 47; k++) begin
         energy_in   = (k >= 11 && k <= 46) ? e : JUNK;
         sweep_start = (spur20 && k == 20);
         bm_state    = (spur20 && k == 20) ? spur_st : st;
         clr_best    = (clr47 && k == 47);
         if (k == 21) busy_at_21 = busy;
         tick();
      end
      sweep_start = 1'b0;
      clr_best    = 1'b0;
      bm_state    = st;
   endtask

   task automatic test_reset();
      apply_reset();
      n_compared += 6;
      if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      if (sweep_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %0b expected 0", sweep_valid); end
      if (best_update !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_update: got %0b expected 0", best_update); end
      if (sweep_energy !== 18'd0) begin n_mismatched++; $display("[TB] FAIL reset_sweep_energy: got %0d expected 0", $signed(sweep_energy)); end
      if (best_energy !== BEST_MAX) begin n_mismatched++; $display("[TB] FAIL reset_best_energy: got %0d expected 131071", $signed(best_energy)); end
      if (best_state !== 144'd0) begin n_mismatched++; $display("[TB] FAIL reset_best_state: got %h expected 0", best_state); end
   endtask

   task automatic test_first_sweep();
      sweep_start = 1'b1;
      bm_state    = st1;
      energy_in   = 12'd5;
      tick();
      sweep_start = 1'b0;
      n_compared++;
      if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_busy_t1: got %0b expected 1", busy); end
      for (int k = 1; k <= 46; k++) tick();
      n_compared += 2;
      if (sweep_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_valid_t47: got %0b expected 0", sweep_valid); end
      if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_busy_t47: got %0b expected 1", busy); end
      tick();
      n_compared += 6;
      if (sweep_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_valid_t48: got %0b expected 1", sweep_valid); end
      if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_busy_t48: got %0b expected 0", busy); end
      if (sweep_energy !== 18'd180) begin n_mismatched++; $display("[TB] FAIL first_sweep_energy: got %0d expected 180", $signed(sweep_energy)); end
      if (best_energy !== 18'd180) begin n_mismatched++; $display("[TB] FAIL first_best_energy: got %0d expected 180", $signed(best_energy)); end
      if (best_update !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_best_update: got %0b expected 1", best_update); end
      if (best_state !== st1) begin n_mismatched++; $display("[TB] FAIL first_best_state: got %h expected %h", best_state, st1); end
      tick();
      n_compared += 2;
      if (sweep_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_valid_t49: got %0b expected 0", sweep_valid); end
      if (best_update !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_update_t49: got %0b expected 0", best_update); end
   endtask

   task automatic test_min_and_zero();
      logic [ACC_W-1:0] exp_min;
      exp_min = 18'(-73728);
      do_sweep(12'h800, st2, 1'b0, '0, 1'b0);
      n_compared += 4;
      if (sweep_energy !== exp_min) begin n_mismatched++; $display("[TB] FAIL min_sweep_energy: got %0d expected -73728", $signed(sweep_energy)); end
      if (best_update !== 1'b1) begin n_mismatched++; $display("[TB] FAIL min_best_update: got %0b expected 1", best_update); end
      if (best_energy !== exp_min) begin n_mismatched++; $display("[TB] FAIL min_best_energy: got %0d expected -73728", $signed(best_energy)); end
      if (best_state !== st2) begin n_mismatched++; $display("[TB] FAIL min_best_state: got %h expected %h", best_state, st2); end
      do_sweep(12'd0, st3, 1'b0, '0, 1'b0);
      n_compared += 4;
      if (sweep_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_valid: got %0b expected 1", sweep_valid); end
      if (sweep_energy !== 18'd0) begin n_mismatched++; $display("[TB] FAIL zero_sweep_energy: got %0d expected 0", $signed(sweep_energy)); end
      if (best_update !== 1'b0) begin n_mismatched++; $display("[TB] FAIL zero_best_update: got %0b expected 0", best_update); end
      if (best_energy !== exp_min) begin n_mismatched++; $display("[TB] FAIL zero_best_energy: got %0d expected -73728", $signed(best_energy)); end
   endtask

   task automatic test_tie();
      do_sweep(12'h800, st4, 1'b0, '0, 1'b0);
      n_compared += 3;
      if (sweep_energy !== 18'(-73728)) begin n_mismatched++; $display("[TB] FAIL tie_sweep_energy: got %0d expected -73728", $signed(sweep_energy)); end
      if (best_update !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_best_update: got %0b expected 0", best_update); end
      if (best_state !== st2) begin n_mismatched++; $display("[TB] FAIL tie_best_state: got %h expected %h", best_state, st2); end
   endtask

   task automatic test_clr_idle();
      clr_best = 1'b1;
      tick();
      clr_best = 1'b0;
      n_compared += 2;
      if (best_energy !== BEST_MAX) begin n_mismatched++; $display("[TB] FAIL clr_best_energy: got %0d expected 131071", $signed(best_energy)); end
      if (best_state !== 144'd0) begin n_mismatched++; $display("[TB] FAIL clr_best_state: got %h expected 0", best_state); end
   endtask

   task automatic test_back_to_back();
      busy_at_21 = 1'b0;
      do_sweep(12'd3, st5, 1'b1, st6, 1'b0);
      n_compared += 5;
      if (busy_at_21 !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_busy: got %0b expected 1", busy_at_21); end
      if (sweep_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_valid: got %0b expected 1", sweep_valid); end
      if (sweep_energy !== 18'd108) begin n_mismatched++; $display("[TB] FAIL spur_sweep_energy: got %0d expected 108", $signed(sweep_energy)); end
      if (best_update !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_best_update: got %0b expected 1", best_update); end
      if (best_state !== st5) begin n_mismatched++; $display("[TB] FAIL spur_best_state: got %h expected %h", best_state, st5); end
   endtask

   task automatic test_clr_at_done();
      do_sweep(12'hFFF, st7, 1'b0, '0, 1'b1);
      n_compared += 5;
      if (sweep_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clrdone_valid: got %0b expected 1", sweep_valid); end
      if (sweep_energy !== 18'(-36)) begin n_mismatched++; $display("[TB] FAIL clrdone_sweep_energy: got %0d expected -36", $signed(sweep_energy)); end
      if (best_update !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clrdone_best_update: got %0b expected 0", best_update); end
      if (best_energy !== BEST_MAX) begin n_mismatched++; $display("[TB] FAIL clrdone_best_energy: got %0d expected 131071", $signed(best_energy)); end
      if (best_state !== 144'd0) begin n_mismatched++; $display("[TB] FAIL clrdone_best_state: got %h expected 0", best_state); end
   endtask

   task automatic test_reset_mid_sweep();
      bit valid_seen;
      do_sweep(12'd1, st8, 1'b0, '0, 1'b0);
      n_compared++;
      if (best_energy !== 18'd36) begin n_mismatched++; $display("[TB] FAIL pre_reset_best_energy: got %0d expected 36", $signed(best_energy)); end
      sweep_start = 1'b1;
      bm_state    = st9;
      energy_in   = 12'd5;
      tick();
      sweep_start = 1'b0;
      for (int k = 1; k < 30; k++) tick();
      rst_n = 1'b0;
      #1;
      n_compared += 6;
      if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_busy: got %0b expected 0", busy); end
      if (sweep_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_valid: got %0b expected 0", sweep_valid); end
      if (best_update !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_update: got %0b expected 0", best_update); end
      if (sweep_energy !== 18'd0) begin n_mismatched++; $display("[TB] FAIL midrst_sweep_energy: got %0d expected 0", $signed(sweep_energy)); end
      if (best_energy !== BEST_MAX) begin n_mismatched++; $display("[TB] FAIL midrst_best_energy: got %0d expected 131071", $signed(best_energy)); end
      if (best_state !== 144'd0) begin n_mismatched++; $display("[TB] FAIL midrst_best_state: got %h expected 0", best_state); end
      tick();
      tick();
      rst_n = 1'b1;
      valid_seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (sweep_valid === 1'b1 || busy === 1'b1) valid_seen = 1'b1;
      end
      n_compared++;
      if (valid_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_no_valid: got %0b expected 0", valid_seen); end
      do_sweep(12'd2, st9, 1'b0, '0, 1'b0);
      n_compared += 4;
      if (sweep_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL postrst_valid: got %0b expected 1", sweep_valid); end
      if (sweep_energy !== 18'd72) begin n_mismatched++; $display("[TB] FAIL postrst_sweep_energy: got %0d expected 72", $signed(sweep_energy)); end
      if (best_update !== 1'b1) begin n_mismatched++; $display("[TB] FAIL postrst_best_update: got %0b expected 1", best_update); end
      if (best_state !== st9) begin n_mismatched++; $display("[TB] FAIL postrst_best_state: got %h expected %h", best_state, st9); end
   endtask

`ifdef SWEEP_COUNT_EN
   task automatic test_sweep_count();
      apply_reset();
      do_sweep(12'd10, st1, 1'b0, '0, 1'b0);
      do_sweep(12'd4, st2, 1'b0, '0, 1'b0);
      do_sweep(12'd7, st3, 1'b0, '0, 1'b0);
      n_compared += 3;
      if (sweep_count !== 16'd3) begin n_mismatched++; $display("[TB] FAIL count_sweep_count: got %0d expected 3", sweep_count); end
      if (best_sweep !== 16'd1) begin n_mismatched++; $display("[TB] FAIL count_best_sweep: got %0d expected 1", best_sweep); end
      if (best_energy !== 18'd144) begin n_mismatched++; $display("[TB] FAIL count_best_energy: got %0d expected 144", $signed(best_energy)); end
      clr_best = 1'b1;
      tick();
      clr_best = 1'b0;
      n_compared += 2;
      if (best_sweep !== 16'd0) begin n_mismatched++; $display("[TB] FAIL count_clr_best_sweep: got %0d expected 0", best_sweep); end
      if (sweep_count !== 16'd3) begin n_mismatched++; $display("[TB] FAIL count_clr_sweep_count: got %0d expected 3", sweep_count); end
   endtask
`endif

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      busy_at_21   = 1'b0;
      st1 = {9{16'hA5C3}};
      st2 = {9{16'h1234}};
      st3 = {9{16'hBEEF}};
      st4 = {9{16'h0F0F}};
      st5 = {9{16'h5A5A}};
      st6 = {9{16'hDEAD}};
      st7 = {9{16'h7777}};
      st8 = {9{16'h3C3C}};
      st9 = {9{16'hC001}};
      test_reset();
      test_first_sweep();
      test_min_and_zero();
      test_tie();
      test_clr_idle();
      test_back_to_back();
      test_clr_at_done();
      test_reset_mid_sweep();
`ifdef SWEEP_COUNT_EN
      test_sweep_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/energy_sweep_accumulator.md
# energy_sweep_accumulator

- Sits directly downstream of the per-phase pipelined energy calculator.
- Sums the 12-bit signed per-phase solution energy over one full phase sweep to form the total network energy of the current spin state.
- Tracks the lowest sweep energy seen and snapshots the matching 144-bit spin state.
- The host reads these results for solution checking.

## Interface
- NUM_PHASES, 36: phases (BRAM words) per sweep; one energy sample per phase.
- PIPE_LAT, 10: cycles from a phase being presented on system_phase to its energy being valid on energy_in.
- ACC_W, 18: accumulator width; must be ≥ 12 + ceil(log2(NUM_PHASES)).
- clk  in  1  system clock, same domain as the energy calculator.
- rst_n  in  1  reset, asynchronous, active-low.
- sweep_start  in  1  one-cycle pulse in the cycle phase 0 is presented to the energy calculator.
- energy_in  in  12  signed two's-complement per-phase energy (energy_reg of the calculator).
- bm_state  in  144  live spin state.
- clr_best  in  1  one-cycle pulse; resets the best-energy record.
- busy  out  1  sweep in progress.
- sweep_energy  out  ACC_W  signed total of the last completed sweep.
- sweep_valid  out  1  one-cycle pulse when sweep_energy updates.
- best_energy  out  ACC_W  signed minimum sweep energy since reset or clr_best.
- best_state  out  144  bm_state snapshot that produced best_energy.
- best_update  out  1  one-cycle pulse, coincident with sweep_valid, when the best record changed.

## Operation
FSM states: IDLE, WAIT, ACCUM, DONE.
- **IDLE:** on sweep_start, capture bm_state into cand_state, clear acc and the cycle counter, go to WAIT. sweep_start in any other state is ignored; no queueing.
- **WAIT:** count PIPE_LAT cycles, then go to ACCUM.
- **ACCUM:** each cycle, acc <= acc + sign_extend(energy_in). After NUM_PHASES samples, go to DONE.
- **DONE** (one cycle):
  - sweep_energy <= acc; sweep_valid <= 1.
  - If acc < best_energy (signed, strict), then best_energy <= acc, best_state <= cand_state, best_update <= 1. Ties keep the older record.
  - Return to IDLE.
- **clr_best:**
  - Sets best_energy to 2^(ACC_W-1)-1 (most positive) and best_state to 0, in any state.
  - If clr_best arrives in the same cycle as a DONE update, clr_best wins and best_update stays 0.
  - clr_best does not affect an in-progress sweep.
- No overflow is possible when ACC_W meets its constraint. The accumulator does not saturate.
- The spin state is sampled once, at sweep_start. The bench drives bm_state as held stable for the sweep, which is how the annealing controller gates it.

## Timing
- sweep_start at cycle t:
  - busy = 1 from t+1 through t+PIPE_LAT+NUM_PHASES+1.
  - energy_in samples are taken at cycles t+PIPE_LAT+1 … t+PIPE_LAT+NUM_PHASES.
  - sweep_valid/best_update are high at cycle t+PIPE_LAT+NUM_PHASES+2.
  - Earliest accepted next sweep_start is t+PIPE_LAT+NUM_PHASES+2.
- Reset values:
  - state = IDLE.
  - busy, sweep_valid, best_update = 0.
  - sweep_energy = 0.
  - best_energy = 2^(ACC_W-1)-1.
  - best_state = 0; cand_state = 0; acc = 0.
- rst_n asserted mid-sweep aborts immediately to reset values. The partial result is never published.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
SWEEP_COUNT_EN, when defined:
- Adds outputs sweep_count[15:0] and best_sweep[15:0], both reset to 0.
- sweep_count increments in each DONE cycle and saturates at 0xFFFF.
- best_sweep <= sweep_count (pre-increment value) whenever best_update fires.
- clr_best zeroes best_sweep but not sweep_count.

Without SWEEP_COUNT_EN, neither the ports nor the counter logic exist.

## Test plan
All scenarios use the defaults PIPE_LAT=10 and NUM_PHASES=36.
- After reset, energy_in held at 5, sweep_start at t=0:
  - sweep_valid at t=48 with sweep_energy=180.
  - best_energy=180, best_update=1, best_state equals the bm_state sampled at t=0.
- Second sweep with energy_in=-2048 throughout: sweep_energy=-73728, best updates. A third sweep at constant 0 gives sweep_energy=0 and no best_update.
- Equal-energy repeat sweep with a different bm_state: best_update=0 and best_state unchanged.
- sweep_start pulsed again at t=20 during a sweep: ignored, result at t=48 unaffected, busy stays high. clr_best coincident with a DONE cycle: best_energy=131071, best_update=0.
- rst_n low at t=30 mid-sweep: all outputs return to reset values, and no sweep_valid occurs. A new sweep after release completes normally.
- With SWEEP_COUNT_EN: three sweeps with energies 10, 4, 7 give sweep_count=3 and best_sweep=1.
